regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data width of each register in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8: number of registers (2..64), with AW = $clog2(DEPTH) derived internally.
REQ-003 The block SHALL have parameter ZERO_R0, default 0: when 1, register 0 reads as zero, ignores writes and is never busy.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port write, input, 1 bit: write enable for the writeback port.
REQ-007 The block SHALL have port reg_w, input, AW bits: writeback register index.
REQ-008 The block SHALL have port data_in, input, WIDTH bits: writeback data.
REQ-009 The block SHALL have port reserve, input, 1 bit: marks reg_r as busy (pending producer).
REQ-010 The block SHALL have port reg_r, input, AW bits: register index to reserve.
REQ-011 The block SHALL have ports reg_a and reg_b, input, AW bits each: read indices.
REQ-012 The block SHALL have ports out_a and out_b, output, WIDTH bits each: read data.
REQ-013 The block SHALL have ports busy_a and busy_b, output, 1 bit each: selected register has a pending write.
REQ-014 The block SHALL have port busy_any, output, 1 bit: OR of all busy bits.
REQ-015 The block SHALL have port err, output, 1 bit: sticky error, reserve of an already-busy register.

Function
REQ-016 Reads SHALL be combinational: out_a = R[reg_a], busy_a = busy[reg_a], and likewise for port b, with zero cycles of latency.
REQ-017 On a rising edge with write=1, R[reg_w] SHALL take data_in and busy[reg_w] SHALL clear; the new value is visible one cycle later (or in the same cycle when REGFILE_BYPASS_EN is defined).
REQ-018 On a rising edge with reserve=1, busy[reg_r] SHALL set.
REQ-019 When write and reserve target the same index in the same cycle, the data SHALL be written and busy SHALL end up set (reserve wins).
REQ-020 When reserve targets a register whose busy bit is set and that register is not being written the same cycle, err SHALL set on that edge, busy SHALL stay set, and err SHALL hold until reset.
REQ-021 Indices at or above DEPTH SHALL be handled as follows: reads return 0 with busy 0; writes and reserves are ignored and do not set err.
REQ-022 When ZERO_R0=1, index 0 SHALL read 0 with busy 0; writes to it and reserves of it are ignored and do not set err.
REQ-023 Writes to different registers SHALL be independent; only the addressed register and its busy bit change.
REQ-024 busy_any SHALL be the combinational OR of the busy vector.

Reset
REQ-025 While reset=1 at a rising edge, all registers SHALL become 0, all busy bits 0, and err 0, so all outputs read 0 the next cycle.
REQ-026 Reset SHALL take priority over write and reserve asserted in the same cycle.
REQ-027 A write or reserve presented during reset SHALL be discarded, with no effect after reset deasserts.

Configuration
REQ-028 When macro REGFILE_BYPASS_EN is defined and write=1 with reg_w == reg_a, out_a SHALL equal data_in and busy_a SHALL be 0 in the same cycle; port b SHALL behave the same way.
REQ-029 When REGFILE_BYPASS_EN is defined and reserve=1 with reg_r == reg_a, busy_a SHALL still report 0 until the edge.
REQ-030 When REGFILE_BYPASS_EN is not defined, reads SHALL return only stored state, with no forwarding.
REQ-031 Bypass SHALL never apply to out-of-range indices or, when ZERO_R0=1, to index 0.

Verification
REQ-032 The bench SHALL cover: reset; write R3=0x1234; then reg_a=3 -> out_a=0x1234, busy_a=0; with bypass, out_a=0x1234 in the write cycle itself.
REQ-033 The bench SHALL cover: reserve R5 -> busy_b=1 (reg_b=5) and busy_any=1 next cycle; write R5=0xBEEF -> busy_b=0, busy_any=0, out_b=0xBEEF.
REQ-034 The bench SHALL cover: reserve R2 twice on consecutive cycles with no write -> err=1 after the second edge, and err stays 1 until reset.
REQ-035 The bench SHALL cover: write R4=0x00AA and reserve R4 in the same cycle -> R4=0x00AA, busy[4]=1, err=0.
REQ-036 The bench SHALL cover: ZERO_R0=1, write R0=0xFFFF -> out_a=0 with reg_a=0; DEPTH=6, write R7 -> ignored, and a read of R7 returns 0.
REQ-037 The bench SHALL cover: write R1=0x5555 and reserve R6, then reset with write=1 in the same cycle -> all outputs 0, busy_any=0, err=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard and sticky reserve error.
// Ports: clk, reset (sync, active-high); write/reg_w/data_in writeback;
// reserve/reg_r busy-marking; reg_a/reg_b read indices -> out_a/out_b,
// busy_a/busy_b; busy_any OR of all busy bits; err sticky double-reserve.
// Optional macro REGFILE_BYPASS_EN forwards writeback data to the reads.
module regfile_sb #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter bit ZERO_R0 = 1'b0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [AW-1:0]    reg_w,
  input  logic [WIDTH-1:0] data_in,
  input  logic             reserve,
  input  logic [AW-1:0]    reg_r,
  input  logic [AW-1:0]    reg_a,
  input  logic [AW-1:0]    reg_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic             busy_any,
  output logic             err
);

  // Storage spans the full index space; entries that are out of
  // range (or r0 when hardwired) are never written and stay zero.
  localparam int NE = 1 << AW;

  logic [WIDTH-1:0] regs_q [NE];
  logic [WIDTH-1:0] regs_d [NE];
  logic [NE-1:0]    busy_q;
  logic [NE-1:0]    busy_d;
  logic             err_q;
  logic             err_d;

  function automatic logic idx_ok(input logic [AW-1:0] idx);
    idx_ok = ({1'b0, idx} < (AW+1)'(DEPTH)) &&
             !(ZERO_R0 && (idx == '0));
  endfunction

  logic wr_ok;
  logic rs_ok;
  logic ra_ok;
  logic rb_ok;

  assign wr_ok = write & idx_ok(reg_w);
  assign rs_ok = reserve & idx_ok(reg_r);
  assign ra_ok = idx_ok(reg_a);
  assign rb_ok = idx_ok(reg_b);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[reg_w] = data_in;
  end

  // Busy clears on writeback; a same-cycle reserve of the same
  // register is applied afterwards so it wins. Reserving a busy
  // register is an error unless that register is retiring now.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_ok) busy_d[reg_w] = 1'b0;
    if (rs_ok) begin
      if (busy_q[reg_r] && !(wr_ok && (reg_w == reg_r)))
        err_d = 1'b1;
      busy_d[reg_r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    out_a  = ra_ok ? regs_q[reg_a] : '0;
    out_b  = rb_ok ? regs_q[reg_b] : '0;
    busy_a = ra_ok & busy_q[reg_a];
    busy_b = rb_ok & busy_q[reg_b];
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes out-of-range and hardwired-zero indices.
    if (ra_ok && wr_ok && (reg_w == reg_a)) begin
      out_a  = data_in;
      busy_a = 1'b0;
    end
    if (rb_ok && wr_ok && (reg_w == reg_b)) begin
      out_b  = data_in;
      busy_b = 1'b0;
    end
`else
    // Reads see stored state only.
`endif
  end

  assign busy_any = |busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default instance (DEPTH 8) and a DEPTH 6 /
// hardwired-r0 instance share stimulus; vector table, corner sequences, random.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [2:0]  reg_w;
  logic [15:0] data_in;
  logic        reserve;
  logic [2:0]  reg_r;
  logic [2:0]  reg_a;
  logic [2:0]  reg_b;

  logic [15:0] oa [2];
  logic [15:0] ob [2];
  logic        ba [2];
  logic        bb [2];
  logic        bany [2];
  logic        er [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .write(write), .reg_w(reg_w),
    .data_in(data_in), .reserve(reserve), .reg_r(reg_r),
    .reg_a(reg_a), .reg_b(reg_b), .out_a(oa[0]), .out_b(ob[0]),
    .busy_a(ba[0]), .busy_b(bb[0]), .busy_any(bany[0]), .err(er[0])
  );

  regfile_sb #(.WIDTH(16), .DEPTH(6), .ZERO_R0(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .write(write), .reg_w(reg_w),
    .data_in(data_in), .reserve(reserve), .reg_r(reg_r),
    .reg_a(reg_a), .reg_b(reg_b), .out_a(oa[1]), .out_b(ob[1]),
    .busy_a(ba[1]), .busy_b(bb[1]), .busy_any(bany[1]), .err(er[1])
  );

  // Reference model: architectural contents per configuration.
  logic [15:0] m_reg  [2][8];
  logic        m_busy [2][8];
  logic        m_err  [2];

  function automatic bit vld(int c, logic [2:0] i);
    if (c == 0) return 1'b1;
    return (i < 3'd6) && (i != 3'd0);
  endfunction

  function automatic logic [15:0] exp_data(int c, logic [2:0] i);
    if (!vld(c, i)) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (write && reg_w == i) return data_in;
`endif
    return m_reg[c][i];
  endfunction

  function automatic logic exp_busy(int c, logic [2:0] i);
    if (!vld(c, i)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (write && reg_w == i) return 1'b0;
`endif
    return m_busy[c][i];
  endfunction

  function automatic logic exp_any(int c);
    logic r = 1'b0;
    for (int k = 0; k < 8; k++) r |= m_busy[c][k];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int k = 0; k < 8; k++) begin
          m_reg[c][k]  <= 16'h0;
          m_busy[c][k] <= 1'b0;
        end
        m_err[c] <= 1'b0;
      end else begin
        if (write && vld(c, reg_w)) begin
          m_reg[c][reg_w]  <= data_in;
          m_busy[c][reg_w] <= 1'b0;
        end
        if (reserve && vld(c, reg_r)) begin
          if (m_busy[c][reg_r] && !(write && reg_w == reg_r))
            m_err[c] <= 1'b1;
          m_busy[c][reg_r] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s d%0d out_a", tag, c), 32'(oa[c]), 32'(exp_data(c, reg_a)));
      chk($sformatf("%s d%0d out_b", tag, c), 32'(ob[c]), 32'(exp_data(c, reg_b)));
      chk($sformatf("%s d%0d busy_a", tag, c), 32'(ba[c]), 32'(exp_busy(c, reg_a)));
      chk($sformatf("%s d%0d busy_b", tag, c), 32'(bb[c]), 32'(exp_busy(c, reg_b)));
      chk($sformatf("%s d%0d busy_any", tag, c), 32'(bany[c]), 32'(exp_any(c)));
      chk($sformatf("%s d%0d err", tag, c), 32'(er[c]), 32'(m_err[c]));
    end
  endtask

  task automatic idle_inputs();
    write = 1'b0; reserve = 1'b0;
    reg_w = 3'd0; reg_r = 3'd0; data_in = 16'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  rw;
    logic [15:0] d;
    logic        rs;
    logic [2:0]  rr;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        eba;
    logic        ebb;
    logic        eany;
    logic        eerr;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd3, 3'd0,
               16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd3, 3'd5,
               16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd5,
               16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 3'd4, 16'h00AA, 1'b1, 3'd4, 3'd4, 3'd3,
               16'h00AA, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 3'd4, 16'h0101, 1'b0, 3'd0, 3'd4, 3'd4,
               16'h0101, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 3'd7, 3'd0,
               16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 3'd0, 16'h0F0F, 1'b0, 3'd0, 3'd0, 3'd7,
               16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd2,
               16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd2,
               16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd2, 3'd1,
               16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    idle_inputs();
    reg_a = 3'd3; reg_b = 3'd5;
    do_reset();
    #1;
    chk("reset out_a", 32'(oa[0]), 32'h0);
    chk("reset out_b", 32'(ob[0]), 32'h0);
    chk("reset busy_any", 32'(bany[0]), 32'h0);
    chk("reset err", 32'(er[0]), 32'h0);

    // Directed vectors on the default instance; checked after the edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      write = tbl[i].wr; reg_w = tbl[i].rw; data_in = tbl[i].d;
      reserve = tbl[i].rs; reg_r = tbl[i].rr;
      reg_a = tbl[i].ra; reg_b = tbl[i].rb;
      @(posedge clk);
      #1;
      write = 1'b0; reserve = 1'b0;
      #1;
      chk($sformatf("v%0d out_a", i), 32'(oa[0]), 32'(tbl[i].ea));
      chk($sformatf("v%0d out_b", i), 32'(ob[0]), 32'(tbl[i].eb));
      chk($sformatf("v%0d busy_a", i), 32'(ba[0]), 32'(tbl[i].eba));
      chk($sformatf("v%0d busy_b", i), 32'(bb[0]), 32'(tbl[i].ebb));
      chk($sformatf("v%0d busy_any", i), 32'(bany[0]), 32'(tbl[i].eany));
      chk($sformatf("v%0d err", i), 32'(er[0]), 32'(tbl[i].eerr));
    end

    // err stays set through idle cycles.
    repeat (3) @(negedge clk);
    chk("err sticky", 32'(er[0]), 32'h1);

    // Same-cycle forwarding (or none), and reserve not visible early.
    @(negedge clk);
    write = 1'b1; reg_w = 3'd3; data_in = 16'h4321;
    reserve = 1'b1; reg_r = 3'd3; reg_a = 3'd3; reg_b = 3'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp out_a", 32'(oa[0]), 32'h4321);
`else
    chk("nobyp out_a", 32'(oa[0]), 32'h1234);
`endif
    chk("byp busy_a", 32'(ba[0]), 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("post byp out_a", 32'(oa[0]), 32'h4321);
    chk("post byp busy_a", 32'(ba[0]), 32'h1);

    // Reset overrides a concurrent write and reserve.
    @(negedge clk);
    write = 1'b1; reg_w = 3'd1; data_in = 16'h5555;
    reserve = 1'b1; reg_r = 3'd6;
    @(negedge clk);
    reset = 1'b1; write = 1'b1; reg_w = 3'd1; data_in = 16'hAAAA;
    reserve = 1'b1; reg_r = 3'd6;
    @(negedge clk);
    reset = 1'b0; idle_inputs();
    reg_a = 3'd1; reg_b = 3'd6;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("rst d%0d out_a", c), 32'(oa[c]), 32'h0);
      chk($sformatf("rst d%0d out_b", c), 32'(ob[c]), 32'h0);
      chk($sformatf("rst d%0d busy_b", c), 32'(bb[c]), 32'h0);
      chk($sformatf("rst d%0d busy_any", c), 32'(bany[c]), 32'h0);
      chk($sformatf("rst d%0d err", c), 32'(er[c]), 32'h0);
    end

    // Hardwired r0 and out-of-range index on the small instance.
    @(negedge clk);
    write = 1'b1; reg_w = 3'd0; data_in = 16'hFFFF; reg_a = 3'd0;
    @(negedge clk);
    write = 1'b1; reg_w = 3'd7; data_in = 16'h7777; reg_b = 3'd7;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("z r0 out_a", 32'(oa[1]), 32'h0);
    chk("z r7 out_b", 32'(ob[1]), 32'h0);
    chk("d8 r0 out_a", 32'(oa[0]), 32'hFFFF);
    chk("d8 r7 out_b", 32'(ob[0]), 32'h7777);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reserve = 1'b1; reg_r = (k < 2) ? 3'd7 : 3'd0;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("z oor err", 32'(er[1]), 32'h0);
    chk("z oor busy_any", 32'(bany[1]), 32'h0);
    chk("z r0 busy_a", 32'(ba[1]), 32'h0);
    chk("d8 dbl err", 32'(er[0]), 32'h1);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 39) == 0);
      write   = ($urandom_range(0, 1) == 1);
      reg_w   = 3'($urandom_range(0, 7));
      data_in = 16'($urandom);
      reserve = ($urandom_range(0, 2) == 0);
      reg_r   = 3'($urandom_range(0, 7));
      reg_a   = ($urandom_range(0, 3) == 0) ? reg_w : 3'($urandom_range(0, 7));
      reg_b   = 3'($urandom_range(0, 7));
      #1;
      chk_model($sformatf("r%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
